// File: rtl/ctrl_hazard_pipe_pkg.sv
// Shared definitions for the RV32I pipelined control unit: opcodes, ALU codes,
// select encodings, the carried control word and small helper functions.
package rv_ctrl_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [2:0]            funct3;
    } ctrl_word_t;

    localparam ctrl_word_t CW_BUBBLE = '0;

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lt,
                                          input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // MEM wins over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic reg_write_m, input logic [4:0] rd_m,
                                           input logic reg_write_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = FWD_MEM;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = FWD_WB;
        else
            sel = FWD_NONE;
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_hazard_pipe_if.sv
// Datapath <-> control unit bundle; master is the datapath, slave the control unit.
interface ctrl_hazard_pipe_if #(parameter int ALUCTL_W = 4);
    logic [31:0]         instr_d;
    logic                zero_e;
    logic                lt_e;
    logic                ltu_e;
    logic [2:0]          imm_src_d;
    logic                stall_f;
    logic                stall_d;
    logic                flush_d;
    logic                flush_e;
    logic                pc_src_e;
    logic                alu_src_e;
    logic [ALUCTL_W-1:0] alu_ctrl_e;
    logic [1:0]          fwd_a_e;
    logic [1:0]          fwd_b_e;
    logic [4:0]          rs1_e;
    logic [4:0]          rs2_e;
    logic [4:0]          rd_e;
    logic                reg_write_m;
    logic                mem_write_m;
    logic [1:0]          result_src_m;
    logic [4:0]          rd_m;
    logic                reg_write_w;
    logic [1:0]          result_src_w;
    logic [4:0]          rd_w;

    modport master (
        output instr_d, zero_e, lt_e, ltu_e,
        input  imm_src_d, stall_f, stall_d, flush_d, flush_e, pc_src_e,
               alu_src_e, alu_ctrl_e, fwd_a_e, fwd_b_e, rs1_e, rs2_e, rd_e,
               reg_write_m, mem_write_m, result_src_m, rd_m,
               reg_write_w, result_src_w, rd_w
    );

    modport slave (
        input  instr_d, zero_e, lt_e, ltu_e,
        output imm_src_d, stall_f, stall_d, flush_d, flush_e, pc_src_e,
               alu_src_e, alu_ctrl_e, fwd_a_e, fwd_b_e, rs1_e, rs2_e, rd_e,
               reg_write_m, mem_write_m, result_src_m, rd_m,
               reg_write_w, result_src_w, rd_w
    );
endinterface

// File: rtl/ctrl_hazard_pipe_decode.sv
// Combinational RV32I decoder: opcode/funct fields to control word and immediate type.
module ctrl_decode
    import rv_ctrl_pkg::*;
#(
    parameter int EXT_ALU = 1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_word_t cw,
    output logic [2:0] imm_src
);

    logic                  is_rtype;
    logic [ALU_CTRL_W-1:0] alu_funct;

    always_comb begin
        is_rtype  = (opcode == OP_RTYPE);
        alu_funct = ALU_ADD;
        if (EXT_ALU != 0) begin
            case (funct3)
                3'b000: alu_funct = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: alu_funct = ALU_SLL;
                3'b010: alu_funct = ALU_SLT;
                3'b011: alu_funct = ALU_SLTU;
                3'b100: alu_funct = ALU_XOR;
                3'b101: alu_funct = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110: alu_funct = ALU_OR;
                3'b111: alu_funct = ALU_AND;
            endcase
        end else if (is_rtype) begin
            // Base set: I-type funct3 is ignored, everything unsupported falls to add.
            case (funct3)
                3'b000:  alu_funct = funct7_5 ? ALU_SUB : ALU_ADD;
                3'b010:  alu_funct = ALU_SLT;
                3'b110:  alu_funct = ALU_OR;
                3'b111:  alu_funct = ALU_AND;
                default: alu_funct = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        cw      = CW_BUBBLE;
        imm_src = IMM_I;
        case (opcode)
            OP_LOAD: begin
                cw.reg_write  = 1'b1;
                cw.alu_src    = 1'b1;
                cw.result_src = RES_MEM;
            end
            OP_STORE: begin
                cw.mem_write = 1'b1;
                cw.alu_src   = 1'b1;
                imm_src      = IMM_S;
            end
            OP_RTYPE: begin
                cw.reg_write = 1'b1;
                cw.alu_ctrl  = alu_funct;
            end
            OP_IALU: begin
                cw.reg_write = 1'b1;
                cw.alu_src   = 1'b1;
                cw.alu_ctrl  = alu_funct;
            end
            OP_BRANCH: begin
                cw.branch   = 1'b1;
                cw.alu_ctrl = ALU_SUB;
                cw.funct3   = funct3;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                cw.jump       = 1'b1;
                cw.reg_write  = 1'b1;
                cw.result_src = RES_PC4;
                imm_src       = IMM_J;
            end
            OP_JALR: begin
                cw.jump       = 1'b1;
                cw.reg_write  = 1'b1;
                cw.alu_src    = 1'b1;
                cw.result_src = RES_PC4;
            end
            OP_LUI: begin
                cw.reg_write  = 1'b1;
                cw.result_src = RES_IMM;
                imm_src       = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_hazard_pipe.sv
// Pipelined control and hazard unit: decode, ID/EX/MEM/WB control registers,
// branch resolve, load-use stall, flush and operand forwarding.
module ctrl_hazard_pipe
    import rv_ctrl_pkg::*;
#(
    parameter int EXT_ALU  = 1,
    parameter int ALUCTL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ctrl_hazard_pipe_if.slave   bus
);

    ctrl_word_t cw_d;
    logic [2:0] imm_src;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       unused_instr_bits;

    ctrl_word_t cw_e;
    logic [4:0] rs1_e, rs2_e, rd_e;

    logic       reg_write_m, mem_write_m;
    logic [1:0] result_src_m;
    logic [4:0] rd_m;

    logic       reg_write_w;
    logic [1:0] result_src_w;
    logic [4:0] rd_w;

    logic       lwstall, pc_src, flush_e;

    assign rs1_d = bus.instr_d[19:15];
    assign rs2_d = bus.instr_d[24:20];
    assign rd_d  = bus.instr_d[11:7];
    assign unused_instr_bits = ^{bus.instr_d[31], bus.instr_d[29:25]};

    ctrl_decode #(.EXT_ALU(EXT_ALU)) u_decode (
        .opcode   (bus.instr_d[6:0]),
        .funct3   (bus.instr_d[14:12]),
        .funct7_5 (bus.instr_d[30]),
        .cw       (cw_d),
        .imm_src  (imm_src)
    );

    assign pc_src  = cw_e.jump | (cw_e.branch & branch_taken(cw_e.funct3, bus.zero_e,
                                                              bus.lt_e, bus.ltu_e));
    assign lwstall = (cw_e.result_src == RES_MEM) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign flush_e = lwstall | pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_e  <= CW_BUBBLE;
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
        end else if (flush_e) begin
            cw_e  <= CW_BUBBLE;
            rs1_e <= '0;
            rs2_e <= '0;
            rd_e  <= '0;
        end else begin
            cw_e  <= cw_d;
            rs1_e <= rs1_d;
            rs2_e <= rs2_d;
            rd_e  <= rd_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            rd_m         <= '0;
            reg_write_w  <= 1'b0;
            result_src_w <= RES_ALU;
            rd_w         <= '0;
        end else begin
            reg_write_m  <= cw_e.reg_write;
            mem_write_m  <= cw_e.mem_write;
            result_src_m <= cw_e.result_src;
            rd_m         <= rd_e;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
        end
    end

    // A redirect discards the stalled instruction anyway, so flush beats stall.
    assign bus.stall_f      = lwstall & !pc_src;
    assign bus.stall_d      = lwstall & !pc_src;
    assign bus.flush_d      = pc_src;
    assign bus.flush_e      = flush_e;
    assign bus.pc_src_e     = pc_src;
    assign bus.imm_src_d    = imm_src;

    assign bus.alu_src_e    = cw_e.alu_src;
    assign bus.alu_ctrl_e   = ALUCTL_W'(cw_e.alu_ctrl);
    assign bus.fwd_a_e      = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    assign bus.fwd_b_e      = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    assign bus.rs1_e        = rs1_e;
    assign bus.rs2_e        = rs2_e;
    assign bus.rd_e         = rd_e;

    assign bus.reg_write_m  = reg_write_m;
    assign bus.mem_write_m  = mem_write_m;
    assign bus.result_src_m = result_src_m;
    assign bus.rd_m         = rd_m;

    assign bus.reg_write_w  = reg_write_w;
    assign bus.result_src_w = result_src_w;
    assign bus.rd_w         = rd_w;

endmodule
